mx2_merge: RTL



---
 rtl/mx2_merge.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mx2_merge.sv
// Two-input round-robin merge of the CX2 primary (A) and copy (B) streams onto one 4-phase Send/Ack channel.
// Latency: Send_x sampled high in IDLE at edge n -> Ack_x, Send_out, Data_out, Src_out valid after edge n.
// Backpressure: one-entry buffer; no new grant until both handshakes have returned to zero and Ack_in is low.
module mx2_merge #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              MR,
   input  logic              Send_a,
   input  logic [DATA_W-1:0] Data_a,
   output logic              Ack_a,
   input  logic              Send_b,
   input  logic [DATA_W-1:0] Data_b,
   output logic              Ack_b,
   output logic              Send_out,
   output logic [DATA_W-1:0] Data_out,
   output logic              Src_out,
   input  logic              Ack_in,
   output logic [CNT_W-1:0]  Pkt_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RTZ  = 2'd2
   } state_t;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t            state;
   state_t            state_nxt;
   logic              last_grant;
   logic              last_grant_nxt;
   logic              ack_a_nxt;
   logic              ack_b_nxt;
   logic              send_out_nxt;
   logic              src_out_nxt;
   logic [DATA_W-1:0] data_out_nxt;
   logic [CNT_W-1:0]  pkt_cnt_nxt;

   logic              grant_vld;
   logic              grant_sel;
   logic              in_release;
   logic              out_release;

   // Round-robin pick: a lone requester wins outright, a tie goes to the input not served last
   always_comb begin
      grant_vld = Send_a | Send_b;
      grant_sel = SRC_A;
      if (Send_a && Send_b) begin
         grant_sel = ~last_grant;
      end else if (Send_b) begin
         grant_sel = SRC_B;
      end
   end

   // Release events of the two handshakes; only the granted input's channel is ever looked at
   always_comb begin
      if (Src_out == SRC_A) begin
         in_release = Ack_a & ~Send_a;
      end else begin
         in_release = Ack_b & ~Send_b;
      end
      out_release = Send_out & Ack_in;
   end

   // Next-state and next-output logic; every register holds unless a transition says otherwise
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      ack_a_nxt      = Ack_a;
      ack_b_nxt      = Ack_b;
      send_out_nxt   = Send_out;
      src_out_nxt    = Src_out;
      data_out_nxt   = Data_out;
      pkt_cnt_nxt    = Pkt_cnt;

      case (state)
         IDLE: begin
            // Ack_in seen here is a downstream protocol error and is deliberately ignored
            if (grant_vld) begin
               data_out_nxt   = (grant_sel == SRC_B) ? Data_b : Data_a;
               src_out_nxt    = grant_sel;
               ack_a_nxt      = (grant_sel == SRC_A);
               ack_b_nxt      = (grant_sel == SRC_B);
               send_out_nxt   = 1'b1;
               last_grant_nxt = grant_sel;
               state_nxt      = BUSY;
            end
         end

         BUSY: begin
            // Input and output sides retire independently, in either order or together
            if (in_release) begin
               if (Src_out == SRC_A) begin
                  ack_a_nxt = 1'b0;
               end else begin
                  ack_b_nxt = 1'b0;
               end
            end
            if (out_release) begin
               send_out_nxt = 1'b0;
               pkt_cnt_nxt  = Pkt_cnt + CNT_ONE;
            end
            if (!ack_a_nxt && !ack_b_nxt && !send_out_nxt) begin
               state_nxt = RTZ;
            end
         end

         RTZ: begin
            // Downstream must drop its acknowledge before the buffer is reused
            if (!Ack_in) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous master reset; B is "last" so A wins the first tie
   always_ff @(posedge CLK) begin
      if (MR) begin
         state      <= IDLE;
         last_grant <= SRC_B;
         Ack_a      <= 1'b0;
         Ack_b      <= 1'b0;
         Send_out   <= 1'b0;
         Src_out    <= SRC_A;
         Data_out   <= '0;
         Pkt_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         Ack_a      <= ack_a_nxt;
         Ack_b      <= ack_b_nxt;
         Send_out   <= send_out_nxt;
         Src_out    <= src_out_nxt;
         Data_out   <= data_out_nxt;
         Pkt_cnt    <= pkt_cnt_nxt;
      end
   end

   // The buffered payload and its source tag must not move while downstream is being offered it
   a_data_stable : assert property (@(posedge CLK) disable iff (MR)
      (Send_out && $past(Send_out)) |-> ($stable(Data_out) && $stable(Src_out)));

   // At most one input is acknowledged at any time
   a_one_ack : assert property (@(posedge CLK) disable iff (MR) !(Ack_a && Ack_b));

endmodule
